// File: rtl/waterfall_key_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : waterfall_key_clk_pkg
// Description : Shared constants for the waterfall LED input-conditioning
//               stage: default system clock and debounce window, the idle
//               (released) button level, and the derivations of the divider
//               half period and the debounce length in clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
package waterfall_key_clk_pkg;

    localparam int   SYS_CLK_FREQ        = 50_000_000;
    localparam int   DEBOUNCE_MS_DEFAULT = 20;

    // Buttons are active-low; a released button reads high.
    localparam logic KEY_IDLE = 1'b1;

    // Number of clk cycles per half period of the divided clock.
    function automatic int half_cycles(input int clk_freq, input int tick_hz);
        return clk_freq / (2 * tick_hz);
    endfunction

    // Number of synchronized samples a key must disagree with its debounced
    // level before the new level is accepted.
    function automatic int db_cycles(input int clk_freq, input int debounce_ms);
        return (clk_freq / 1000) * debounce_ms;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/waterfall_key_clk_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Debouncer for one raw active-low push-button. Two-flop
//               synchronizer followed by a mismatch counter; a new level is
//               accepted after DB_CYCLES consecutive disagreeing samples. A
//               debounced press (1->0) raises `press` for one clk cycle;
//               releases are silent.
// Ports       : clk   - system clock
//               clr   - asynchronous active-high reset
//               key_n - raw button, active-low, asynchronous to clk
//               press - one-cycle pulse on a debounced press
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import waterfall_key_clk_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic key_n,
    output logic press
);

    localparam int                 c_cnt_w    = cnt_width(DB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_db_cnt;
    logic [1:0]         r_vld;
    logic               r_armed;
    logic               r_press;

    // r_vld marks when r_sync2 holds a real sample rather than its reset
    // value. A key must be seen released through the synchronizer before it
    // can generate a press, so a button held down across a reset stays silent
    // until it is let go and pressed again.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sync1  <= KEY_IDLE;
            r_sync2  <= KEY_IDLE;
            r_stable <= KEY_IDLE;
            r_db_cnt <= '0;
            r_vld    <= 2'b00;
            r_armed  <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            r_press <= 1'b0;

            if (r_vld[1] && (r_sync2 == KEY_IDLE)) begin
                r_armed <= 1'b1;
            end

            if (r_sync2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_cnt_last) begin
                // Disagreement held for the full window: accept new level.
                r_stable <= r_sync2;
                r_db_cnt <= '0;
                if ((r_stable == KEY_IDLE) && r_armed) begin
                    r_press <= 1'b1;
                end
            end else begin
                r_db_cnt <= r_db_cnt + c_cnt_w'(1);
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/waterfall_key_clk.sv
`default_nettype none
// ============================================================================
// Module      : waterfall_key_clk
// Description : Input-conditioning stage of the waterfall LED controller.
//               Divides clk into a 50 % duty step clock with a rising-edge
//               tick, debounces the stop and clear buttons, keeps the
//               run/stop level and issues a one-cycle active-low clear.
// Ports       : clk      - system clock
//               clr      - asynchronous active-high reset
//               key_stop - raw stop button, active-low
//               key_clr  - raw clear button, active-low
//               clk_1hz  - divided clock, registered
//               tick     - one-clk pulse on each rising edge of clk_1hz
//               stop_n   - 1 = run, 0 = hold
//               clr_n    - one-cycle active-low clear to the counter
// Revision    : 1.0 - initial release
// ============================================================================
module waterfall_key_clk
    import waterfall_key_clk_pkg::*;
#(
    parameter int CLK_FREQ    = SYS_CLK_FREQ,
    parameter int TICK_HZ     = 1,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
    input  logic clk,
    input  logic clr,
    input  logic key_stop,
    input  logic key_clr,
    output logic clk_1hz,
    output logic tick,
    output logic stop_n,
    output logic clr_n
);

    // Both derived values must be at least 1 for the block to function.
    localparam int                 c_half     = half_cycles(CLK_FREQ, TICK_HZ);
    localparam int                 c_db       = db_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int                 c_div_w    = cnt_width(c_half);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_half - 1);

    logic               w_stop_press;
    logic               w_clr_press;
    logic [c_div_w-1:0] r_div_cnt;
    logic               r_clk_1hz;
    logic               r_tick;
    logic               r_run;
    logic               r_clr_n;

    key_debounce #(
        .DB_CYCLES (c_db)
    ) u_stop_db (
        .clk   (clk),
        .clr   (clr),
        .key_n (key_stop),
        .press (w_stop_press)
    );

    key_debounce #(
        .DB_CYCLES (c_db)
    ) u_clr_db (
        .clk   (clk),
        .clr   (clr),
        .key_n (key_clr),
        .press (w_clr_press)
    );

    // Divider. A clear press restarts the phase so the counter downstream
    // sees its first step a full half period after the clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_div_cnt <= '0;
            r_clk_1hz <= 1'b0;
            r_tick    <= 1'b0;
        end else if (w_clr_press) begin
            r_div_cnt <= '0;
            r_clk_1hz <= 1'b0;
            r_tick    <= 1'b0;
        end else if (r_div_cnt == c_div_last) begin
            r_div_cnt <= '0;
            r_clk_1hz <= ~r_clk_1hz;
            r_tick    <= ~r_clk_1hz;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_w'(1);
            r_tick    <= 1'b0;
        end
    end

    // Run level and clear pulse. Clear dominates a simultaneous stop press,
    // and a stop press landing while clr_n is low is dropped as well.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_run   <= 1'b1;
            r_clr_n <= 1'b0;
        end else begin
            r_clr_n <= ~w_clr_press;
            if (w_clr_press) begin
                r_run <= 1'b1;
            end else if (w_stop_press && r_clr_n) begin
                r_run <= ~r_run;
            end
        end
    end

    assign clk_1hz = r_clk_1hz;
    assign tick    = r_tick;
    assign stop_n  = r_run;
    assign clr_n   = r_clr_n;

endmodule
`default_nettype wire

// File: tb/tb_waterfall_key_clk.sv
`default_nettype none
// ============================================================================
// Module      : tb_waterfall_key_clk
// Description : Scoreboard bench for waterfall_key_clk. A reference model,
//               advanced once per clk edge, pushes the expected outputs for
//               that edge into a queue; a monitor pops and compares them
//               shortly after each edge. Directed scenarios are followed by
//               a randomized key phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_waterfall_key_clk;

    localparam int CLK_FREQ    = 1000;
    localparam int TICK_HZ     = 100;
    localparam int DEBOUNCE_MS = 4;
    localparam int HALF        = CLK_FREQ / (2 * TICK_HZ);       // 5
    localparam int DB          = (CLK_FREQ / 1000) * DEBOUNCE_MS; // 4

    logic clk = 1'b0;
    logic clr;
    logic key_stop;
    logic key_clr;
    logic clk_1hz;
    logic tick;
    logic stop_n;
    logic clr_n;

    int total = 0;
    int bad   = 0;

    waterfall_key_clk #(
        .CLK_FREQ    (CLK_FREQ),
        .TICK_HZ     (TICK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .key_stop (key_stop),
        .key_clr  (key_clr),
        .clk_1hz  (clk_1hz),
        .tick     (tick),
        .stop_n   (stop_n),
        .clr_n    (clr_n)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int   cyc;
        logic clk_1hz;
        logic tick;
        logic stop_n;
        logic clr_n;
    } exp_t;

    exp_t exp_q[$];

    // Per key (0 = stop, 1 = clear): debounced level, length of the current
    // run of raw samples disagreeing with it, and whether the key has been
    // seen released since reset.
    logic k_stable [2];
    int   k_run    [2];
    logic k_armed  [2];
    int   stop_due [$];
    int   clr_due  [$];

    int   m_cyc;
    int   m_phase;
    logic m_stop_n;
    logic m_clr_n;

    task automatic key_sample(input int k, input logic raw, output logic fire);
        fire = 1'b0;
        if (raw != k_stable[k]) begin
            k_run[k]++;
            if (k_run[k] == DB) begin
                k_stable[k] = raw;
                k_run[k]    = 0;
                fire        = (raw == 1'b0) && k_armed[k];
            end
        end else begin
            k_run[k] = 0;
        end
        if (raw) k_armed[k] = 1'b1;
    endtask

    task automatic model_step();
        logic fs, fc, es, ec;
        exp_t e;
        if (clr) begin
            for (int k = 0; k < 2; k++) begin
                k_stable[k] = 1'b1;
                k_run[k]    = 0;
                k_armed[k]  = 1'b0;
            end
            stop_due.delete();
            clr_due.delete();
            m_cyc    = 0;
            m_phase  = 0;
            m_stop_n = 1'b1;
            m_clr_n  = 1'b0;
        end else begin
            m_cyc++;
            key_sample(0, key_stop, fs);
            key_sample(1, key_clr, fc);
            // The output reacts three edges after the sample that completes
            // the debounce window.
            if (fs) stop_due.push_back(m_cyc + 3);
            if (fc) clr_due.push_back(m_cyc + 3);
            es = 1'b0;
            ec = 1'b0;
            if (stop_due.size() > 0 && stop_due[0] == m_cyc) begin
                es = 1'b1;
                void'(stop_due.pop_front());
            end
            if (clr_due.size() > 0 && clr_due[0] == m_cyc) begin
                ec = 1'b1;
                void'(clr_due.pop_front());
            end
            if (ec) begin
                m_stop_n = 1'b1;
                m_clr_n  = 1'b0;
                m_phase  = 0;
            end else begin
                if (es && m_clr_n) m_stop_n = ~m_stop_n;
                m_clr_n = 1'b1;
                m_phase++;
            end
        end
        e.cyc     = m_cyc;
        e.clk_1hz = (clr) ? 1'b0 : ((m_phase % (2 * HALF)) >= HALF);
        e.tick    = (clr) ? 1'b0 : ((m_phase % (2 * HALF)) == HALF);
        e.stop_n  = m_stop_n;
        e.clr_n   = m_clr_n;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow: got no expected entry, need one per edge");
            end else begin
                e = exp_q.pop_front();
                if ({clk_1hz, tick, stop_n, clr_n} !== {e.clk_1hz, e.tick, e.stop_n, e.clr_n}) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d: got clk_1hz=%b tick=%b stop_n=%b clr_n=%b, expected %b %b %b %b",
                             e.cyc, clk_1hz, tick, stop_n, clr_n,
                             e.clk_1hz, e.tick, e.stop_n, e.clr_n);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_now(input string name);
        total++;
        if ({clk_1hz, tick, stop_n, clr_n} !== 4'b0010) begin
            bad++;
            $display("FAIL %s: got clk_1hz=%b tick=%b stop_n=%b clr_n=%b, expected 0 0 1 0",
                     name, clk_1hz, tick, stop_n, clr_n);
        end
    endtask

    initial begin
        clr      = 1'b1;
        key_stop = 1'b1;
        key_clr  = 1'b1;

        // Reset held for three edges, then divider free-runs.
        cycles(3);
        check_reset_now("reset_hold");
        clr = 1'b0;
        cycles(30);

        // Two full stop presses: hold, then run again.
        repeat (2) begin
            key_stop = 1'b0; cycles(20);
            key_stop = 1'b1; cycles(20);
        end

        // Bouncing stop key: never DB low samples in a row.
        repeat (5) begin
            key_stop = 1'b0; cycles(3);
            key_stop = 1'b1; cycles(1);
        end
        cycles(20);

        // Clear while held and with the divider mid-count.
        key_stop = 1'b0; cycles(20);
        key_stop = 1'b1; cycles(13);
        key_clr  = 1'b0; cycles(20);
        key_clr  = 1'b1; cycles(20);

        // Both keys pressed together while running.
        key_stop = 1'b0; key_clr = 1'b0; cycles(20);
        key_stop = 1'b1; key_clr = 1'b1; cycles(20);

        // Randomized key activity.
        for (int seg = 0; seg < 40; seg++) begin
            key_stop = 1'($urandom_range(0, 1));
            key_clr  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            cycles($urandom_range(1, 12));
        end
        key_stop = 1'b1;
        key_clr  = 1'b1;
        cycles(20);

        // Reset in the middle of a stop press; key still down afterwards.
        key_stop = 1'b0;
        cycles(4);
        clr = 1'b1;
        #1;
        check_reset_now("async_reset");
        cycles(2);
        check_reset_now("reset_held_mid_press");
        clr = 1'b0;
        cycles(25);
        key_stop = 1'b1; cycles(20);
        key_stop = 1'b0; cycles(20);
        key_stop = 1'b1; cycles(20);

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
